// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave bridging a synchronous-clock TX holding register and RX word
// register to an external master; all SPI pins are oversampled in the clk domain.
module spi_slave_bridge #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic              r_ss_s1, r_ss_s2, r_ss_d;
    logic              r_mosi_s1, r_mosi_s2;
    logic [DATA_W-1:0] r_hold, r_tx_shift, r_rx_shift, r_rx_data;
    logic              r_hold_full, r_word_done, r_rx_valid, r_overrun, r_underrun;
    logic [CW-1:0]     r_bit_cnt;
    logic              w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic              w_load, w_shift_tx, w_sample, w_abort, w_complete;

    // ss_n idles high so a reset never looks like a frame start by itself
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
            r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_d   <= 1'b1;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
            r_ss_s1   <= spi_ss_n; r_ss_s2   <= r_ss_s1;   r_ss_d   <= r_ss_s2;
            r_mosi_s1 <= spi_mosi; r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_ss_fall   = ~r_ss_s2 & r_ss_d;
    assign w_ss_rise   = r_ss_s2 & ~r_ss_d;
    assign w_complete  = (r_bit_cnt == CNT_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_tx  = 1'b0;
        w_sample    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_sample = w_sclk_rise;
                    // falling edge after a finished word presents the next word's MSB
                    if (w_sclk_fall) begin
                        if (r_word_done) w_load     = 1'b1;
                        else             w_shift_tx = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;

            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_load) begin
                r_word_done <= 1'b0;
                if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_shift <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (w_shift_tx) begin
                r_tx_shift <= r_tx_shift << 1;
            end

            if (w_complete) begin
                r_rx_data   <= r_rx_shift;
                r_rx_valid  <= 1'b1;
                r_overrun   <= r_rx_valid && !rx_ready;
                r_bit_cnt   <= '0;
                r_word_done <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[DATA_W-2:0], r_mosi_s2};
                r_bit_cnt  <= r_bit_cnt + CW'(1);
            end

            if (w_abort) begin
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_tx_shift  <= '0;
                r_word_done <= 1'b0;
            end
        end
    end

    assign spi_miso    = (r_state == ST_SHIFT) ? r_tx_shift[DATA_W-1] : 1'b0;
    assign spi_miso_oe = (r_state == ST_SHIFT);
    assign busy        = (r_state == ST_SHIFT);
    assign tx_ready    = !r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_overrun;
    assign tx_underrun = r_underrun;
endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench: a behavioural mode-0 master (sclk = clk/16) drives the bridge
// and each scenario task compares against hand-computed values.
module tb_spi_slave_bridge;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0;
    logic       rx_overrun, tx_underrun, busy;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0, udr_cnt = 0, rxpos_cnt = 0;
    logic rx_valid_q = 1'b0;

    spi_slave_bridge #(.DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_overrun)  ovr_cnt++;
        if (tx_underrun) udr_cnt++;
        if (rx_valid && !rx_valid_q) rxpos_cnt++;
        rx_valid_q <= rx_valid;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wclk(1);
        tx_valid = 1'b0;
    endtask

    task automatic consume_rx();
        rx_ready = 1'b1;
        wclk(1);
        rx_ready = 1'b0;
    endtask

    // Sends the top n bits of mo, MSB first; mi collects MISO at each sclk rise.
    task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[7-i];
            wclk(8);
            spi_sclk = 1'b1;
            mi = {mi[6:0], spi_miso};
            wclk(8);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic ss_low();
        spi_ss_n = 1'b0;
        wclk(6);
    endtask

    task automatic ss_high();
        wclk(8);
        spi_ss_n = 1'b1;
        wclk(8);
    endtask

    task automatic test_reset();
        wclk(3);
        reset_n = 1'b1;
        wclk(3);
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
        checks++; if (spi_miso !== 1'b0)    begin errors++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
        checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_overrun !== 1'b0 || tx_underrun !== 1'b0)
            begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", rx_overrun, tx_underrun); end
    endtask

    task automatic test_single_word();
        logic [7:0] mi;
        write_tx(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_hold_full got=%b exp=0", tx_ready); end
        ss_low();
        checks++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1)
            begin errors++; $display("FAIL single_busy got=%b%b exp=11", busy, spi_miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_tx_ready got=%b exp=1", tx_ready); end
        spi_bits(8, 8'h3C, mi);
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL single_miso got=%h exp=a5", mi); end
        ss_high();
        checks++; if (rx_data !== 8'h3C)   begin errors++; $display("FAIL single_rx_data got=%h exp=3c", rx_data); end
        checks++; if (rx_valid !== 1'b1)   begin errors++; $display("FAIL single_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (busy !== 1'b0 || spi_miso !== 1'b0)
            begin errors++; $display("FAIL single_idle got=%b%b exp=00", busy, spi_miso); end
        consume_rx();
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL single_consume got=%b exp=0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        int u0, o0;
        rx_ready = 1'b1;
        write_tx(8'h81);
        u0 = udr_cnt; o0 = ovr_cnt;
        ss_low();
        spi_bits(8, 8'hAA, mi);
        checks++; if (mi !== 8'h81) begin errors++; $display("FAIL b2b_word0 got=%h exp=81", mi); end
        wclk(6);
        checks++; if (udr_cnt - u0 !== 1) begin errors++; $display("FAIL b2b_underrun got=%0d exp=1", udr_cnt - u0); end
        spi_bits(8, 8'h55, mi);
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL b2b_word1 got=%h exp=00", mi); end
        ss_high();
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL b2b_rx_data got=%h exp=55", rx_data); end
        checks++; if (rx_valid !== 1'b0 || ovr_cnt != o0)
            begin errors++; $display("FAIL b2b_drained got=%b/%0d exp=0/0", rx_valid, ovr_cnt - o0); end
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        int o0;
        o0 = ovr_cnt;
        ss_low();
        spi_bits(8, 8'h11, mi);
        spi_bits(8, 8'h22, mi);
        ss_high();
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt - o0); end
        checks++; if (rx_data !== 8'h22)  begin errors++; $display("FAIL ovr_rx_data got=%h exp=22", rx_data); end
        wclk(20);
        checks++; if (rx_valid !== 1'b1)  begin errors++; $display("FAIL ovr_rx_valid got=%b exp=1", rx_valid); end
        consume_rx();
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL ovr_consume got=%b exp=0", rx_valid); end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int r0;
        r0 = rxpos_cnt;
        ss_low();
        spi_bits(5, 8'hF8, mi);
        ss_high();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0 || rxpos_cnt != r0)
            begin errors++; $display("FAIL abort_no_word got=%b/%0d exp=0/0", rx_valid, rxpos_cnt - r0); end
        ss_low();
        spi_bits(8, 8'h5A, mi);
        ss_high();
        checks++; if (rx_data !== 8'h5A || rx_valid !== 1'b1)
            begin errors++; $display("FAIL abort_next got=%h/%b exp=5a/1", rx_data, rx_valid); end
        consume_rx();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        write_tx(8'h77);
        ss_low();
        spi_bits(3, 8'hE0, mi);
        reset_n = 1'b0;
        wclk(2);
        checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got=%b%b%b exp=000", busy, spi_miso_oe, spi_miso); end
        checks++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00)
            begin errors++; $display("FAIL rstmid_regs got=%b/%b/%h exp=1/0/00", tx_ready, rx_valid, rx_data); end
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        wclk(2);
        reset_n = 1'b1;
        wclk(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_wait got=%b exp=0", busy); end
        ss_low();
        spi_bits(8, 8'hC3, mi);
        ss_high();
        checks++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1)
            begin errors++; $display("FAIL rstmid_next got=%h/%b exp=c3/1", rx_data, rx_valid); end
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL rstmid_miso got=%h exp=00", mi); end
        consume_rx();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
